// File: rtl/pipe_fetch.sv
// IF stage plus IF/ID pipeline register: PC selection, ready/valid instruction fetch,
// a one-entry skid for words that return while decode is stalled, and a pending redirect.
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    input  logic        wpcir,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      state, state_nx;
    logic [31:0] pc_nx, dpc4_nx, inst_nx;
    logic [31:0] skid_pc4, skid_inst, skid_pc4_nx, skid_inst_nx;
    logic        pend_v, pend_v_nx;
    logic [31:0] pend_pc, pend_pc_nx;
    logic [31:0] pc4, target, npc;
    logic        req_c;

    assign pc4 = pc + 32'd4;

    always_comb begin
        target = pc4;
        case (pcsource)
            2'b00: target = pc4;
            2'b01: target = bpc;
            2'b10: target = rpc;
            2'b11: target = jpc;
            default: target = pc4;
        endcase
    end

    // A redirect seen during a bubble is remembered, because decode has moved on
    // to the NOP by the time the delay slot finally arrives.
    assign npc = pend_v ? pend_pc : target;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= FETCH;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        dpc4_nx      = dpc4;
        inst_nx      = inst;
        skid_pc4_nx  = skid_pc4;
        skid_inst_nx = skid_inst;
        pend_v_nx    = pend_v;
        pend_pc_nx   = pend_pc;
        req_c        = 1'b0;
        case (state)
            FETCH: begin
                req_c = 1'b1;
                if (imem_ready) begin
                    if (wpcir) begin
                        dpc4_nx   = pc4;
                        inst_nx   = imem_rdata;
                        pc_nx     = npc;
                        pend_v_nx = 1'b0;
                    end else begin
                        skid_pc4_nx  = pc4;
                        skid_inst_nx = imem_rdata;
                        state_nx     = HOLD;
                    end
                end else if (wpcir) begin
                    inst_nx = NOP_INST;
                    if (pcsource != 2'b00 && !pend_v) begin
                        pend_pc_nx = target;
                        pend_v_nx  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (wpcir) begin
                    dpc4_nx   = skid_pc4;
                    inst_nx   = skid_inst;
                    pc_nx     = npc;
                    pend_v_nx = 1'b0;
                    state_nx  = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc        <= RESET_PC;
            dpc4      <= 32'h0;
            inst      <= NOP_INST;
            skid_pc4  <= 32'h0;
            skid_inst <= NOP_INST;
            pend_v    <= 1'b0;
            pend_pc   <= 32'h0;
        end else begin
            pc        <= pc_nx;
            dpc4      <= dpc4_nx;
            inst      <= inst_nx;
            skid_pc4  <= skid_pc4_nx;
            skid_inst <= skid_inst_nx;
            pend_v    <= pend_v_nx;
            pend_pc   <= pend_pc_nx;
        end
    end

    assign imem_req  = req_c & resetn;
    assign imem_addr = pc;

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch; instruction memory returns word(addr) = addr>>2.
module tb_pipe_fetch;

    logic        clock = 1'b0;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, rpc;
    logic        wpcir, imem_ready;
    logic [31:0] imem_rdata, imem_addr, pc, dpc4, inst;
    logic        imem_req;
    logic [31:0] w_rdata, w_addr, w_pc, w_dpc4, w_inst;
    logic        w_req;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign imem_rdata = imem_addr >> 2;
    assign w_rdata    = w_addr >> 2;

    pipe_fetch u_dut (
        .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .rpc(rpc),
        .wpcir(wpcir), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_req(imem_req), .pc(pc), .dpc4(dpc4), .inst(inst)
    );

    pipe_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .rpc(rpc),
        .wpcir(wpcir), .imem_rdata(w_rdata), .imem_ready(imem_ready),
        .imem_addr(w_addr), .imem_req(w_req), .pc(w_pc), .dpc4(w_dpc4), .inst(w_inst)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_ifid(input string name, input logic [31:0] epc,
                               input logic [31:0] edpc4, input logic [31:0] einst);
        // plain sequencing of three inline compares for one pipeline snapshot
        checks++;
        if (pc !== epc) begin failures++; $display("FAIL %s pc got=%h exp=%h", name, pc, epc); end
        checks++;
        if (dpc4 !== edpc4) begin failures++; $display("FAIL %s dpc4 got=%h exp=%h", name, dpc4, edpc4); end
        checks++;
        if (inst !== einst) begin failures++; $display("FAIL %s inst got=%h exp=%h", name, inst, einst); end
    endtask

    task automatic apply_reset();
        resetn = 1'b0; pcsource = 2'b00; bpc = 0; jpc = 0; rpc = 0; wpcir = 1'b1; imem_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; pcsource = 2'b00; bpc = 0; jpc = 0; rpc = 0; wpcir = 1'b1; imem_ready = 1'b1;
        #2;
        expect_ifid("reset", 32'h0, 32'h0, 32'h0);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        apply_reset();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++; $display("FAIL reset_release req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 5; i++) begin
            tick();
            expect_ifid($sformatf("seq%0d", i), 32'(4 * i), 32'(4 * i), 32'(i - 1));
        end
    endtask

    task automatic test_branch();
        // pc=0x14 now; beq at 0x10 is in decode
        pcsource = 2'b01; bpc = 32'h40;
        tick();
        expect_ifid("branch_slot", 32'h40, 32'h18, 32'h5);
        pcsource = 2'b00;
        tick();
        expect_ifid("branch_tgt", 32'h44, 32'h44, 32'h10);
    endtask

    task automatic test_stall();
        wpcir = 1'b0; imem_ready = 1'b1;
        tick();
        expect_ifid("stall1", 32'h44, 32'h44, 32'h10);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL stall1_req got=%b exp=0", imem_req); end
        tick();
        expect_ifid("stall2", 32'h44, 32'h44, 32'h10);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL stall2_req got=%b exp=0", imem_req); end
        wpcir = 1'b1;
        tick();
        expect_ifid("stall_release", 32'h48, 32'h48, 32'h11);
        checks++;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL stall_release_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_slow_memory();
        // j in decode with delay slot at 0x48 not yet returned
        pcsource = 2'b11; jpc = 32'h100; imem_ready = 1'b0;
        tick();
        expect_ifid("slow_bub1", 32'h48, 32'h48, 32'h0);
        pcsource = 2'b00;
        tick();
        expect_ifid("slow_bub2", 32'h48, 32'h48, 32'h0);
        imem_ready = 1'b1;
        tick();
        expect_ifid("slow_slot", 32'h100, 32'h4C, 32'h12);
        tick();
        expect_ifid("slow_tgt", 32'h104, 32'h104, 32'h40);
    endtask

    task automatic test_jr();
        pcsource = 2'b10; rpc = 32'h2000_0008;
        tick();
        expect_ifid("jr_slot", 32'h2000_0008, 32'h108, 32'h41);
        pcsource = 2'b00;
        tick();
        expect_ifid("jr_tgt", 32'h2000_000C, 32'h2000_000C, 32'h0800_0002);
    endtask

    task automatic test_wrap();
        apply_reset();
        checks++;
        if (w_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_reset_pc got=%h exp=fffffffc", w_pc); end
        tick();
        checks++;
        if (w_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=00000000", w_pc); end
        checks++;
        if (w_inst !== 32'h3FFF_FFFF || w_dpc4 !== 32'h0) begin
            failures++; $display("FAIL wrap_ifid inst=%h dpc4=%h exp inst=3fffffff dpc4=0", w_inst, w_dpc4);
        end
    endtask

    task automatic test_reset_midreq();
        // run to pc=8, then record a pending jump while memory is slow
        tick();
        imem_ready = 1'b0; pcsource = 2'b11; jpc = 32'h300;
        tick();
        #2 resetn = 1'b0;
        #1;
        expect_ifid("rst_req_async", 32'h0, 32'h0, 32'h0);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req_req got=%b exp=0", imem_req); end
        @(negedge clock);
        resetn = 1'b1; imem_ready = 1'b1; pcsource = 2'b00;
        tick();
        expect_ifid("rst_req_restart", 32'h4, 32'h4, 32'h0);
    endtask

    task automatic test_reset_hold();
        // pc=4: stall so the word at 4 lands in the skid
        wpcir = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_hold_in_hold got=%b exp=0", imem_req); end
        #2 resetn = 1'b0;
        #1;
        expect_ifid("rst_hold_async", 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        resetn = 1'b1; wpcir = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_hold_req got=%b exp=1", imem_req); end
        tick();
        expect_ifid("rst_hold_restart", 32'h4, 32'h4, 32'h0);
        tick();
        expect_ifid("rst_hold_next", 32'h8, 32'h8, 32'h1);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_slow_memory();
        test_jr();
        test_wrap();
        test_reset_midreq();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_fetch.md
Name: pipe_fetch

Overview:
- IF stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
- Holds the PC and selects the next PC from the decode-stage redirect (pcsource/bpc/jpc/register target).
- Fetches from instruction memory over a ready/valid handshake and presents dpc4/inst to decode.
- Honours the decode stall (wpcir). One architectural branch delay slot: no flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0000, bubble instruction (sll $0,$0,0) injected into IF/ID.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
pcsource  in  2  from decode: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
bpc  in  32  branch target from decode.
jpc  in  32  jump target from decode.
rpc  in  32  register target (jr), forwarded da from decode.
wpcir  in  1  1 = decode accepts a new IF/ID value; 0 = stall.
imem_rdata  in  32  instruction data, valid when imem_ready=1.
imem_ready  in  1  instruction memory completes the current request this cycle.
imem_addr  out  32  fetch address (= pc).
imem_req  out  1  fetch request.
pc  out  32  current fetch PC.
dpc4  out  32  IF/ID: PC+4 of the instruction in decode.
inst  out  32  IF/ID: instruction in decode.

Behaviour:
- Interface: one clock (clock); reset resetn is asynchronous and active-low. All state updates on the rising edge.
- Reset: pc=RESET_PC, dpc4=0, inst=NOP_INST, state=FETCH, pend_v=0, skid empty, imem_req=0 while resetn=0.
- npc: 32-bit wrap-around adder, pc+4.
  - If pend_v=1, npc=pend_pc.
  - Otherwise npc comes from pcsource (00 pc+4, 01 bpc, 10 rpc, 11 jpc).
- FSM states: FETCH and HOLD.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=1 and wpcir=1: IF/ID <= {pc+4, imem_rdata}; pc <= npc; pend_v <= 0.
  - imem_ready=1 and wpcir=0: skid <= {pc+4, imem_rdata}; go to HOLD; pc holds.
  - imem_ready=0 and wpcir=1: IF/ID <= {dpc4, NOP_INST} (bubble); pc holds.
  - imem_ready=0 and wpcir=1 and pcsource!=00 and pend_v=0: pend_pc <= selected target; pend_v <= 1. The redirect issued for the delay slot being fetched is kept.
  - imem_ready=0 and wpcir=0: no change.
- HOLD: imem_req=0.
  - wpcir=1: IF/ID <= skid; pc <= npc; pend_v <= 0; go to FETCH.
  - wpcir=0: hold everything.
- Stall priority: wpcir=0 freezes IF/ID and pc regardless of the redirect. Decode holds its instruction, so pcsource stays valid.
- Latency: with imem_ready tied to 1, an instruction at address A appears in inst the cycle after pc=A. Throughput is 1 instruction/clock.
- Delay slot: the instruction fetched in the same cycle the branch sits in decode always enters IF/ID. The target is fetched next.
- Reset asserted mid-request or in HOLD: the request is abandoned and the skid and pend_v are discarded. An imem_ready arriving after resetn rises belongs to a new request at RESET_PC. Memory must not complete an abandoned request.
- imem_ready while imem_req=0: ignored.

Test Plan:
- Reset then ready=1, wpcir=1, pcsource=00, memory word[i]=i: pc steps 0,4,8,…; inst=0,1,2 one cycle after the matching pc; dpc4=pc+4 of each.
- Branch: beq at 0x10 in decode with pcsource=01, bpc=0x40 → delay slot at 0x14 enters IF/ID; next pc=0x40; no flush.
- Stall: wpcir=0 for 2 cycles with ready=1 → FSM enters HOLD, req=0, inst/dpc4/pc frozen; on wpcir=1 the skid word is delivered and pc advances by 4.
- Slow memory: ready delayed 2 cycles while decode holds j with jpc=0x100 → two NOP bubbles; pend_v set; delay slot delivered; then pc=0x100.
- jr: pcsource=10, rpc=0x2000_0008 → pc=0x2000_0008 after the delay slot; pc wrap: RESET_PC=0xFFFF_FFFC, sequential → next pc=0x0.
- resetn pulse while waiting on imem (ready=0) and again in HOLD → pc=RESET_PC, inst=0, dpc4=0, pend_v=0 immediately (asynchronous); fetch restarts at RESET_PC.
